// File: rtl/cpu_feeder.sv
// cpu_feeder: plays a counted sequence of 16-bit instructions from a small
// store into the CPU over the load/start/waiting handshake, and returns each
// retired result (cpu_out plus N,V,Z) as a one-cycle strobe.
// Optional watchdog: define CPU_FEEDER_WATCHDOG_EN to compile it in.
module cpu_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [15:0]   prog_data_i,
  input  logic          run_i,
  input  logic [AW:0]   count_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          load_o,
  output logic          start_o,
  output logic [15:0]   instr_o,
  input  logic          waiting_i,
  input  logic [15:0]   cpu_out_i,
  input  logic          cpu_n_i,
  input  logic          cpu_v_i,
  input  logic          cpu_z_i,
  output logic          res_valid_o,
  output logic [AW-1:0] res_idx_o,
  output logic [15:0]   res_data_o,
  output logic [2:0]    res_nvz_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_ACK,
    S_EXEC
  } state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   n_q, n_d;
  logic [15:0]   instr_q, instr_d;
  logic          done_q, done_d;
  logic          waiting_q;
  logic          res_valid_q, res_valid_d;
  logic [AW-1:0] res_idx_q, res_idx_d;
  logic [15:0]   res_data_q, res_data_d;
  logic [2:0]    res_nvz_q, res_nvz_d;
  logic [15:0]   mem_q [DEPTH];

  logic          write_en;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic          last_instr;
  logic          wd_fire;

  // Host writes only land while idle; anything else is dropped.
  assign write_en   = prog_we_i && (state_q == S_IDLE);
  assign last_instr = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));

  // Instruction store; deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  // Next-state, sequencing and result-capture decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    instr_d     = instr_q;
    done_d      = 1'b0;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    res_nvz_d   = res_nvz_q;
    fetch_en    = 1'b0;
    fetch_addr  = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          if (count_i == '0) begin
            done_d = 1'b1;
          end else begin
            idx_d      = '0;
            n_d        = (count_i > DEPTH_W) ? DEPTH_W : count_i;
            fetch_en   = 1'b1;
            fetch_addr = '0;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        state_d = S_START;
      end
      S_START: begin
        if (waiting_q) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!waiting_i) begin
          state_d = S_EXEC;
        end else if (wd_fire) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (waiting_i) begin
          res_valid_d = 1'b1;
          res_idx_d   = idx_q;
          res_data_d  = cpu_out_i;
          res_nvz_d   = {cpu_n_i, cpu_v_i, cpu_z_i};
          if (last_instr) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d      = idx_q + AW'(1);
            fetch_en   = 1'b1;
            fetch_addr = idx_q + AW'(1);
            state_d    = S_LOAD;
          end
        end else if (wd_fire) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A write in the same cycle as the fetch is forwarded so it is not missed.
    if (fetch_en) begin
      instr_d = (write_en && (prog_addr_i == fetch_addr)) ? prog_data_i
                                                          : mem_q[fetch_addr];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      instr_q     <= '0;
      done_q      <= 1'b0;
      waiting_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      res_nvz_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      instr_q     <= instr_d;
      done_q      <= done_d;
      waiting_q   <= waiting_i;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
      res_nvz_q   <= res_nvz_d;
    end
  end

`ifdef CPU_FEEDER_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  assign wd_fire = ((state_q == S_ACK) || (state_q == S_EXEC)) &&
                   (wd_q == WW'(TIMEOUT - 1));

  // Watchdog count runs only across ACK and EXEC; it is zero again before ACK.
  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if ((state_q == S_ACK) || (state_q == S_EXEC)) begin
      wd_d = wd_q + WW'(1);
    end
    if ((state_q == S_IDLE) && run_i && (count_i != '0)) begin
      err_d = 1'b0;
    end
    if (wd_fire && (((state_q == S_ACK) && waiting_i) ||
                    ((state_q == S_EXEC) && !waiting_i))) begin
      err_d = 1'b1;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign wd_fire = 1'b0;
  assign err_o   = 1'b0;
`endif

  // start uses the registered waiting so it never depends combinationally
  // on the CPU; the one-cycle lag is harmless because the CPU only drops
  // waiting after it has seen start.
  assign busy_o      = (state_q != S_IDLE);
  assign load_o      = (state_q == S_LOAD);
  assign start_o     = (state_q == S_START) && waiting_q;
  assign done_o      = done_q;
  assign instr_o     = instr_q;
  assign res_valid_o = res_valid_q;
  assign res_idx_o   = res_idx_q;
  assign res_data_o  = res_data_q;
  assign res_nvz_o   = res_nvz_q;

endmodule

// File: tb/tb_cpu_feeder.sv
// tb_cpu_feeder: directed bench for cpu_feeder with a small stub CPU that
// understands MOV Rd,#imm (Dxxx) and a fixed ADD R2 = R0 + R1 (Axxx).
module tb_cpu_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        progWe;
  logic [3:0]  progAddr;
  logic [15:0] progData;
  logic        run;
  logic [4:0]  count;
  logic        busy, done, err, load, start;
  logic [15:0] instr;
  logic        waiting;
  logic [15:0] cpuOut;
  logic        cpuN, cpuV, cpuZ;
  logic        resValid;
  logic [3:0]  resIdx;
  logic [15:0] resData;
  logic [2:0]  resNvz;

  int errors = 0;
  int checks = 0;

  // Stub CPU state.
  logic        stubWaiting, stubBusy, stubHang, holdLow;
  int          execLat;
  int          stubCnt;
  logic [15:0] stubInstr;
  logic [15:0] stubRegs [4];
  logic [15:0] stubResult;

  // Monitor counters and result log.
  int          loadCnt, startCnt, overlapCnt, loadLong, startLong;
  int          resCnt, doneCnt, doneWithRes;
  logic        prevLoad = 1'b0;
  logic        prevStart = 1'b0;
  logic [3:0]  logIdx  [32];
  logic [15:0] logData [32];
  logic [2:0]  logNvz  [32];

  always #5 clk = ~clk;

  assign waiting = stubWaiting & ~holdLow;

  cpu_feeder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .prog_we_i   (progWe),
    .prog_addr_i (progAddr),
    .prog_data_i (progData),
    .run_i       (run),
    .count_i     (count),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .load_o      (load),
    .start_o     (start),
    .instr_o     (instr),
    .waiting_i   (waiting),
    .cpu_out_i   (cpuOut),
    .cpu_n_i     (cpuN),
    .cpu_v_i     (cpuV),
    .cpu_z_i     (cpuZ),
    .res_valid_o (resValid),
    .res_idx_o   (resIdx),
    .res_data_o  (resData),
    .res_nvz_o   (resNvz)
  );

  // Stub CPU: drops waiting on start, raises it execLat cycles later with a result.
  always @(posedge clk) begin
    if (rst) begin
      stubWaiting <= 1'b1;
      stubBusy    <= 1'b0;
      stubCnt     <= 0;
      stubInstr   <= 16'h0000;
      cpuOut      <= 16'h0000;
      cpuN        <= 1'b0;
      cpuV        <= 1'b0;
      cpuZ        <= 1'b0;
      for (int i = 0; i < 4; i++) stubRegs[i] <= 16'h0000;
    end else if (start && !stubBusy) begin
      stubWaiting <= 1'b0;
      stubBusy    <= 1'b1;
      stubCnt     <= execLat;
      stubInstr   <= instr;
    end else if (stubBusy && !stubHang) begin
      if (stubCnt <= 1) begin
        if (stubInstr[15:12] == 4'hD) begin
          stubResult = {8'h00, stubInstr[7:0]};
          stubRegs[stubInstr[9:8]] <= stubResult;
        end else if (stubInstr[15:12] == 4'hA) begin
          stubResult = stubRegs[0] + stubRegs[1];
          stubRegs[2] <= stubResult;
        end else begin
          stubResult = 16'h0000;
        end
        cpuOut      <= stubResult;
        cpuN        <= stubResult[15];
        cpuV        <= 1'b0;
        cpuZ        <= (stubResult == 16'h0000);
        stubWaiting <= 1'b1;
        stubBusy    <= 1'b0;
      end else begin
        stubCnt <= stubCnt - 1;
      end
    end
  end

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (load) loadCnt++;
    if (start) startCnt++;
    if (load && prevLoad) loadLong++;
    if (start && prevStart) startLong++;
    if (load && start) overlapCnt++;
    prevLoad  = load;
    prevStart = start;
    if (resValid) begin
      if (resCnt < 32) begin
        logIdx[resCnt]  = resIdx;
        logData[resCnt] = resData;
        logNvz[resCnt]  = resNvz;
      end
      resCnt++;
    end
    if (done) begin
      doneCnt++;
      if (resValid) doneWithRes++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of host inputs, then returns them to idle.
  task automatic applyStimulus(input logic we, input logic [3:0] addr,
                               input logic [15:0] data, input logic go,
                               input logic [4:0] cnt);
    progWe   = we;
    progAddr = addr;
    progData = data;
    run      = go;
    count    = cnt;
    tick();
    progWe = 1'b0;
    run    = 1'b0;
  endtask

  task automatic clearMon();
    loadCnt = 0; startCnt = 0; overlapCnt = 0; loadLong = 0; startLong = 0;
    resCnt = 0; doneCnt = 0; doneWithRes = 0;
  endtask

  task automatic waitDone(input int maxCycles, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < maxCycles && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    checkOutput(tag, {31'b0, got}, 32'd1);
    tick();
  endtask

  task automatic checkSeq3(input string tag);
    checkOutput({tag, "_resCnt"}, resCnt, 3);
    checkOutput({tag, "_idx0"}, {28'b0, logIdx[0]}, 0);
    checkOutput({tag, "_idx1"}, {28'b0, logIdx[1]}, 1);
    checkOutput({tag, "_idx2"}, {28'b0, logIdx[2]}, 2);
    checkOutput({tag, "_data0"}, {16'b0, logData[0]}, 32'h0007);
    checkOutput({tag, "_data1"}, {16'b0, logData[1]}, 32'h0002);
    checkOutput({tag, "_data2"}, {16'b0, logData[2]}, 32'h0009);
    checkOutput({tag, "_nvz2"}, {29'b0, logNvz[2]}, 0);
    checkOutput({tag, "_doneWithRes"}, doneWithRes, 1);
  endtask

  initial begin
    int snapLoad, snapStart, ackCycles;
    logic seen;
    rst = 1'b1; progWe = 1'b0; progAddr = '0; progData = '0; run = 1'b0;
    count = '0; stubHang = 1'b0; holdLow = 1'b0; execLat = 2;
    clearMon();

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_done", {31'b0, done}, 0);
    checkOutput("rst_err", {31'b0, err}, 0);
    checkOutput("rst_load", {31'b0, load}, 0);
    checkOutput("rst_start", {31'b0, start}, 0);
    checkOutput("rst_resValid", {31'b0, resValid}, 0);
    checkOutput("rst_instr", {16'b0, instr}, 0);
    checkOutput("rst_resData", {16'b0, resData}, 0);
    checkOutput("rst_resIdx", {28'b0, resIdx}, 0);
    checkOutput("rst_resNvz", {29'b0, resNvz}, 0);
    tick();

    // Program MOV R0,#7 / MOV R1,#2 / ADD R2,R1,R0 and run three.
    applyStimulus(1'b1, 4'd0, 16'hD007, 1'b0, 5'd0);
    applyStimulus(1'b1, 4'd1, 16'hD102, 1'b0, 5'd0);
    applyStimulus(1'b1, 4'd2, 16'hA140, 1'b0, 5'd0);
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd3);
    @(negedge clk);
    checkOutput("run_loadT1", {31'b0, load}, 1);
    checkOutput("run_busy", {31'b0, busy}, 1);
    checkOutput("run_instr0", {16'b0, instr}, 32'hD007);
    @(negedge clk);
    checkOutput("run_startT2", {31'b0, start}, 1);
    checkOutput("run_loadOffT2", {31'b0, load}, 0);
    waitDone(200, "run_doneSeen");
    checkSeq3("run");
    checkOutput("run_loadCnt", loadCnt, 3);
    checkOutput("run_startCnt", startCnt, 3);
    checkOutput("run_overlap", overlapCnt, 0);
    checkOutput("run_loadLong", loadLong, 0);
    checkOutput("run_startLong", startLong, 0);
    checkOutput("run_instrHold", {16'b0, instr}, 32'hA140);
    checkOutput("run_busyEnd", {31'b0, busy}, 0);

    // count = 0: done next cycle, never busy, no load.
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd0);
    @(negedge clk);
    checkOutput("zero_done", {31'b0, done}, 1);
    checkOutput("zero_busy", {31'b0, busy}, 0);
    checkOutput("zero_load", {31'b0, load}, 0);
    @(negedge clk);
    checkOutput("zero_donePulse", {31'b0, done}, 0);
    checkOutput("zero_loadCnt", loadCnt, 0);
    tick();

    // CPU not ready: start must wait for waiting to rise.
    holdLow = 1'b1;
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd1);
    repeat (5) tick();
    checkOutput("hold_noStart", startCnt, 0);
    checkOutput("hold_busy", {31'b0, busy}, 1);
    holdLow = 1'b0;
    waitDone(100, "hold_doneSeen");
    checkOutput("hold_startCnt", startCnt, 1);
    checkOutput("hold_loadCnt", loadCnt, 1);
    checkOutput("hold_loadLong", loadLong, 0);
    checkOutput("hold_data0", {16'b0, logData[0]}, 32'h0007);

    // Write and run while busy are both ignored.
    execLat = 6;
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd3);
    repeat (3) tick();
    checkOutput("busyIgn_busy", {31'b0, busy}, 1);
    applyStimulus(1'b1, 4'd0, 16'hD0FF, 1'b1, 5'd1);
    waitDone(300, "busyIgn_doneSeen");
    checkOutput("busyIgn_resCnt", resCnt, 3);
    checkOutput("busyIgn_doneCnt", doneCnt, 1);
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd3);
    waitDone(300, "rerun_doneSeen");
    checkSeq3("rerun");

    // Reset during EXEC of slot 1.
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd3);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (startCnt >= 2) seen = 1'b1;
    end
    checkOutput("midRst_secondStart", {31'b0, seen}, 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRst_busy", {31'b0, busy}, 0);
    snapLoad  = loadCnt;
    snapStart = startCnt;
    repeat (20) tick();
    checkOutput("midRst_noLoad", loadCnt, snapLoad);
    checkOutput("midRst_noStart", startCnt, snapStart);
    checkOutput("midRst_resCnt", resCnt, 1);
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd3);
    waitDone(300, "postRst_doneSeen");
    checkSeq3("postRst");

    // count above DEPTH is clamped to DEPTH.
    for (int s = 3; s < 16; s++) applyStimulus(1'b1, s[3:0], {8'hD0, s[7:0]}, 1'b0, 5'd0);
    execLat = 1;
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd31);
    waitDone(600, "clamp_doneSeen");
    checkOutput("clamp_resCnt", resCnt, 16);
    checkOutput("clamp_idx15", {28'b0, logIdx[15]}, 15);
    checkOutput("clamp_data15", {16'b0, logData[15]}, 32'h000F);
    checkOutput("clamp_data2", {16'b0, logData[2]}, 32'h0009);
    checkOutput("clamp_doneWithRes", doneWithRes, 1);
    checkOutput("clamp_err", {31'b0, err}, 0);

`ifdef CPU_FEEDER_WATCHDOG_EN
    // Hung CPU: err and done 64 cycles after ACK entry, no result.
    stubHang = 1'b1;
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (start) seen = 1'b1;
    end
    checkOutput("wd_startSeen", {31'b0, seen}, 1);
    @(negedge clk);
    ackCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      ackCycles++;
      if (done) seen = 1'b1;
    end
    checkOutput("wd_doneSeen", {31'b0, seen}, 1);
    checkOutput("wd_cycles", ackCycles, 64);
    checkOutput("wd_err", {31'b0, err}, 1);
    tick();
    checkOutput("wd_noRes", resCnt, 0);
    checkOutput("wd_errSticky", {31'b0, err}, 1);
    stubHang = 1'b0;
    repeat (10) tick();
    clearMon();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 5'd1);
    @(negedge clk);
    checkOutput("wd_errCleared", {31'b0, err}, 0);
    waitDone(100, "wd_rerunDone");
    checkOutput("wd_rerunRes", resCnt, 1);
`else
    ackCycles = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
